frame_resize_sequencer: RTL and testbench

Frame-level controller placed between the RGB frame source and `frame_resize`, in the `clk` domain. On command it admits a requested number of whole frames into the resize core, discarding partial-frame traffic and gating the stream at frame boundaries. It checks line and frame geometry against `N_x`/`N_y` and waits a fixed drain interval after each frame so the resize pipeline can empty. It reports `busy`, `done` and sticky error flags to the system controller.

---
 rtl/resize_pkg.sv | 36 +++
 rtl/frame_geom_checker.sv | 86 ++++++++
 rtl/frame_resize_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_frame_resize_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resize_pkg.sv
// rtl/resize_pkg.sv - shared types and constants for the resize path
// Contents:
//   DW                  pixel width, R[23:16] G[15:8] B[7:0]
//   R_LSB/G_LSB/B_LSB   RGB field offsets, CH_W channel width
//   seq_state_t         sequencer state encoding
//   geom_err_t          geometry error codes from frame_geom_checker
//   sat_inc8            saturating 8-bit increment
package resize_pkg;

  localparam int DW    = 24;
  localparam int CH_W  = 8;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOF = 3'd1,
    ST_PASS     = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    GERR_NONE        = 2'd0,
    GERR_SOF         = 2'd1,
    GERR_EOL_EARLY   = 2'd2,
    GERR_EOL_MISSING = 2'd3
  } geom_err_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_geom_checker.sv
// rtl/frame_geom_checker.sv - x/y position tracking and SOF/EOL checks
// Ports:
//   i_clk, i_rst     clock, async active-high reset
//   i_clear          synchronous clear of x/y
//   i_sof_mode       waiting for SOF: only a tvalid&tuser beat is accepted
//   i_check_mode     inside a frame: every valid beat is checked
//   i_tvalid/tuser/tlast  input beat qualifiers
//   o_beat_ok        beat may be forwarded
//   o_frame_end      accepted beat is the last of the frame
//   o_err            error raised by the current beat (beat is rejected)
module frame_geom_checker
  import resize_pkg::*;
#(
  parameter int N_x = 64,
  parameter int N_y = 48
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_clear,
  input  logic      i_sof_mode,
  input  logic      i_check_mode,
  input  logic      i_tvalid,
  input  logic      i_tuser,
  input  logic      i_tlast,
  output logic      o_beat_ok,
  output logic      o_frame_end,
  output geom_err_t o_err
);

  localparam int XW = $clog2(N_x);
  localparam int YW = $clog2(N_y);
  localparam logic [XW-1:0] X_LAST = XW'(N_x - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(N_y - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_last;
  logic          w_y_last;

  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  // SOF beats are accepted unchecked; in-frame beats are checked SOF first,
  // then early EOL, then missing EOL.
  always_comb begin
    o_beat_ok   = 1'b0;
    o_frame_end = 1'b0;
    o_err       = GERR_NONE;
    if (i_sof_mode) begin
      o_beat_ok = i_tvalid & i_tuser;
    end else if (i_check_mode && i_tvalid) begin
      if (i_tuser) begin
        o_err = GERR_SOF;
      end else if (i_tlast && !w_x_last) begin
        o_err = GERR_EOL_EARLY;
      end else if (!i_tlast && w_x_last) begin
        o_err = GERR_EOL_MISSING;
      end else begin
        o_beat_ok   = 1'b1;
        o_frame_end = w_x_last & w_y_last;
      end
    end
  end

  // The SOF beat itself is x=0,y=0, so the next expected position is x=1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clear) begin
      r_x <= '0;
      r_y <= '0;
    end else if (o_beat_ok) begin
      if (i_sof_mode) begin
        r_x <= XW'(1);
        r_y <= '0;
      end else if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_resize_sequencer.sv
// rtl/frame_resize_sequencer.sv - admits whole frames into frame_resize
// Ports:
//   i_clk, i_rst                    clock, async active-high reset
//   i_start, i_abort, i_frames      command pulse, abort, frame count
//   i_s_axis_t*                     source stream (no backpressure)
//   o_m_axis_t*                     gated, registered stream to frame_resize
//   o_busy                          high in WAIT_SOF, PASS, DRAIN
//   o_done                          one-cycle pulse after the last drain
//   o_err_eol_early/missing, o_err_sof  sticky geometry error flags
//   o_frames_done                   frames completed since last start
module frame_resize_sequencer
  import resize_pkg::*;
#(
  parameter int N_x          = 64,
  parameter int N_y          = 48,
  parameter int DRAIN_CYCLES = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic [7:0]    i_frames,
  input  logic          i_s_axis_tvalid,
  input  logic          i_s_axis_tuser,
  input  logic          i_s_axis_tlast,
  input  logic [DW-1:0] i_s_axis_tdata,
  output logic          o_m_axis_tvalid,
  output logic          o_m_axis_tuser,
  output logic          o_m_axis_tlast,
  output logic [DW-1:0] o_m_axis_tdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err_eol_early,
  output logic          o_err_eol_missing,
  output logic          o_err_sof,
  output logic [7:0]    o_frames_done
);

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(DRAIN_CYCLES - 1);

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;
  logic [7:0]    r_frames_left;
  logic [7:0]    r_frames_done;
  logic [DCW-1:0] r_drain_cnt;
  logic          r_m_tvalid;
  logic          r_m_tuser;
  logic          r_m_tlast;
  logic [DW-1:0] r_m_tdata;
  logic          r_done;
  logic          r_err_eol_early;
  logic          r_err_eol_missing;
  logic          r_err_sof;

  logic          w_start_ok;
  logic          w_drain_last;
  logic          w_beat_ok;
  logic          w_frame_end;
  geom_err_t     w_geom_err;
  logic          w_forward;
  logic          w_busy;
  logic          w_done_set;

  // abort beats start; a zero frame count makes start a no-op
  assign w_start_ok   = i_start & ~i_abort & (i_frames != 8'd0) &
                        ((r_state == ST_IDLE) | (r_state == ST_ERROR));
  assign w_drain_last = (r_drain_cnt == DC_LAST);

  frame_geom_checker #(
    .N_x (N_x),
    .N_y (N_y)
  ) u_geom (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_abort | w_start_ok),
    .i_sof_mode   (r_state == ST_WAIT_SOF),
    .i_check_mode (r_state == ST_PASS),
    .i_tvalid     (i_s_axis_tvalid),
    .i_tuser      (i_s_axis_tuser),
    .i_tlast      (i_s_axis_tlast),
    .o_beat_ok    (w_beat_ok),
    .o_frame_end  (w_frame_end),
    .o_err        (w_geom_err)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (w_start_ok) w_state_nxt = ST_WAIT_SOF;
        ST_WAIT_SOF: if (w_beat_ok) w_state_nxt = ST_PASS;
        ST_PASS: begin
          if (w_geom_err != GERR_NONE) w_state_nxt = ST_ERROR;
          else if (w_frame_end)        w_state_nxt = ST_DRAIN;
        end
        // frames_left was already decremented on the frame's last beat
        ST_DRAIN: if (w_drain_last)
          w_state_nxt = (r_frames_left == 8'd0) ? ST_DONE : ST_WAIT_SOF;
        ST_DONE:     w_state_nxt = ST_IDLE;
        ST_ERROR:    if (w_start_ok) w_state_nxt = ST_WAIT_SOF;
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // beat_ok is only ever raised in WAIT_SOF or PASS
  always_comb begin
    w_forward  = w_beat_ok & ~i_abort;
    w_busy     = (r_state == ST_WAIT_SOF) | (r_state == ST_PASS) |
                 (r_state == ST_DRAIN);
    w_done_set = (r_state == ST_DONE) & ~i_abort;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_m_tvalid        <= 1'b0;
      r_m_tuser         <= 1'b0;
      r_m_tlast         <= 1'b0;
      r_m_tdata         <= '0;
      r_done            <= 1'b0;
      r_frames_left     <= 8'd0;
      r_frames_done     <= 8'd0;
      r_drain_cnt       <= '0;
      r_err_eol_early   <= 1'b0;
      r_err_eol_missing <= 1'b0;
      r_err_sof         <= 1'b0;
    end else begin
      r_m_tvalid <= w_forward;
      if (w_forward) begin
        r_m_tuser <= i_s_axis_tuser;
        r_m_tlast <= i_s_axis_tlast;
        r_m_tdata <= i_s_axis_tdata;
      end
      r_done <= w_done_set;

      if (i_abort) begin
        r_frames_left     <= 8'd0;
        r_drain_cnt       <= '0;
        r_err_eol_early   <= 1'b0;
        r_err_eol_missing <= 1'b0;
        r_err_sof         <= 1'b0;
      end else if (w_start_ok) begin
        r_frames_left     <= i_frames;
        r_frames_done     <= 8'd0;
        r_drain_cnt       <= '0;
        r_err_eol_early   <= 1'b0;
        r_err_eol_missing <= 1'b0;
        r_err_sof         <= 1'b0;
      end else begin
        if (r_state == ST_PASS) begin
          case (w_geom_err)
            GERR_SOF:         r_err_sof         <= 1'b1;
            GERR_EOL_EARLY:   r_err_eol_early   <= 1'b1;
            GERR_EOL_MISSING: r_err_eol_missing <= 1'b1;
            default:          ;
          endcase
          if (w_frame_end) begin
            r_frames_left <= r_frames_left - 8'd1;
            r_frames_done <= sat_inc8(r_frames_done);
          end
        end
        if (r_state == ST_DRAIN)
          r_drain_cnt <= w_drain_last ? '0 : r_drain_cnt + 1'b1;
      end
    end
  end

  assign o_m_axis_tvalid   = r_m_tvalid;
  assign o_m_axis_tuser    = r_m_tuser;
  assign o_m_axis_tlast    = r_m_tlast;
  assign o_m_axis_tdata    = r_m_tdata;
  assign o_busy            = w_busy;
  assign o_done            = r_done;
  assign o_err_eol_early   = r_err_eol_early;
  assign o_err_eol_missing = r_err_eol_missing;
  assign o_err_sof         = r_err_sof;
  assign o_frames_done     = r_frames_done;

endmodule

// File: tb/tb_frame_resize_sequencer.sv
// tb/tb_frame_resize_sequencer.sv - self-checking bench for frame_resize_sequencer
module tb_frame_resize_sequencer;
  import resize_pkg::*;

  localparam int NX = 8;
  localparam int NY = 4;
  localparam int DC = 6;

  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_PASS  = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;
  localparam int P_ERROR = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    frames = 8'd0;
  logic          s_tv = 1'b0, s_tu = 1'b0, s_tl = 1'b0;
  logic [DW-1:0] s_td = '0;
  logic          m_tv, m_tu, m_tl;
  logic [DW-1:0] m_td;
  logic          busy, done, e_early, e_miss, e_sof;
  logic [7:0]    fdone;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frame_resize_sequencer #(
    .N_x          (NX),
    .N_y          (NY),
    .DRAIN_CYCLES (DC)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_start           (start),
    .i_abort           (abort),
    .i_frames          (frames),
    .i_s_axis_tvalid   (s_tv),
    .i_s_axis_tuser    (s_tu),
    .i_s_axis_tlast    (s_tl),
    .i_s_axis_tdata    (s_td),
    .o_m_axis_tvalid   (m_tv),
    .o_m_axis_tuser    (m_tu),
    .o_m_axis_tlast    (m_tl),
    .o_m_axis_tdata    (m_td),
    .o_busy            (busy),
    .o_done            (done),
    .o_err_eol_early   (e_early),
    .o_err_eol_missing (e_miss),
    .o_err_sof         (e_sof),
    .o_frames_done     (fdone)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Behavioural model: walks the source beat by beat through the frame
  // admission rules and predicts the registered outputs after each edge.
  int            m_ph = P_IDLE, m_x = 0, m_y = 0, m_left = 0, m_fd = 0, m_dr = 0;
  logic          m_ee = 1'b0, m_em = 1'b0, m_es = 1'b0;
  logic          x_tv = 1'b0, x_tu = 1'b0, x_tl = 1'b0, x_done = 1'b0;
  logic [DW-1:0] x_td = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = P_IDLE; m_x = 0; m_y = 0; m_left = 0; m_fd = 0; m_dr = 0;
      m_ee = 0; m_em = 0; m_es = 0;
      x_tv = 0; x_tu = 0; x_tl = 0; x_done = 0; x_td = '0;
    end else begin
      x_tv = 0;
      x_done = 0;
      if (abort) begin
        m_ph = P_IDLE; m_x = 0; m_y = 0; m_left = 0; m_dr = 0;
        m_ee = 0; m_em = 0; m_es = 0;
      end else begin
        case (m_ph)
          P_IDLE, P_ERROR: if (start && frames != 0) begin
            m_left = frames; m_fd = 0; m_x = 0; m_y = 0; m_dr = 0;
            m_ee = 0; m_em = 0; m_es = 0;
            m_ph = P_WAIT;
          end
          P_WAIT: if (s_tv && s_tu) begin
            x_tv = 1; x_tu = s_tu; x_tl = s_tl; x_td = s_td;
            m_x = 1; m_y = 0; m_ph = P_PASS;
          end
          P_PASS: if (s_tv) begin
            if (s_tu) begin
              m_es = 1; m_ph = P_ERROR;
            end else if (s_tl && m_x != NX - 1) begin
              m_ee = 1; m_ph = P_ERROR;
            end else if (!s_tl && m_x == NX - 1) begin
              m_em = 1; m_ph = P_ERROR;
            end else begin
              x_tv = 1; x_tu = s_tu; x_tl = s_tl; x_td = s_td;
              m_x++;
              if (m_x == NX) begin
                m_x = 0;
                m_y++;
                if (m_y == NY) begin
                  m_y = 0;
                  m_left--;
                  m_fd = (m_fd < 255) ? m_fd + 1 : 255;
                  m_dr = 0;
                  m_ph = P_DRAIN;
                end
              end
            end
          end
          P_DRAIN: begin
            m_dr++;
            if (m_dr == DC) m_ph = (m_left == 0) ? P_DONE : P_WAIT;
          end
          P_DONE: begin
            x_done = 1;
            m_ph = P_IDLE;
          end
          default: m_ph = P_IDLE;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_tvalid", m_tv, x_tv);
      chk("m_tdata", m_td, x_td);
      if (x_tv) begin
        chk("m_tuser", m_tu, x_tu);
        chk("m_tlast", m_tl, x_tl);
      end
      chk("done", done, x_done);
      chk("busy", busy, (m_ph == P_WAIT || m_ph == P_PASS || m_ph == P_DRAIN));
      chk("err_flags", {e_early, e_miss, e_sof}, {m_ee, m_em, m_es});
      chk("frames_done", fdone, m_fd);
    end
  end

  // Observed output stream statistics for the hand-computed checks
  int n_beats = 0;
  int n_done = 0;
  int sof_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (m_tv) begin
        if (m_tu) sof_q.push_back(n_beats);
        n_beats++;
      end
      if (done) n_done++;
    end
  end

  function automatic int sof_at(input int k);
    return (k < sof_q.size()) ? sof_q[k] : -1;
  endfunction

  task automatic clr_obs();
    n_beats = 0;
    n_done = 0;
    sof_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_tv = 0; s_tu = 0; s_tl = 0;
  endtask

  task automatic gap(input int n);
    idle();
    repeat (n) tick();
  endtask

  task automatic pulse_start(input int n);
    idle();
    start = 1;
    frames = 8'(n);
    tick();
    start = 0;
  endtask

  task automatic pulse_abort();
    idle();
    abort = 1;
    tick();
    abort = 0;
  endtask

  // inj: 0 none, 1 force tlast, 2 drop tlast, 3 force tuser at (inj_y, inj_x)
  task automatic send_frame(input int first_line, input int inj, input int inj_y,
                            input int inj_x, input int abort_at, input int stop_at);
    int i;
    i = 0;
    for (int y = first_line; y < NY; y++) begin
      for (int x = 0; x < NX; x++) begin
        logic tu, tl;
        tu = (x == 0 && y == 0);
        tl = (x == NX - 1);
        if (y == inj_y && x == inj_x) begin
          if (inj == 1) tl = 1;
          if (inj == 2) tl = 0;
          if (inj == 3) tu = 1;
        end
        s_tv = 1; s_tu = tu; s_tl = tl; s_td = DW'($urandom());
        if (i == abort_at) begin
          abort = 1; start = 1; frames = 8'd3;
        end
        tick();
        if (i == abort_at) begin
          abort = 0; start = 0;
          chk("abort_next_tvalid", m_tv, 1'b0);
          chk("abort_busy", busy, 1'b0);
        end
        i++;
        if (i == stop_at) begin
          idle();
          return;
        end
      end
    end
    idle();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tv, 1'b0);
    chk("rst_tdata", m_td, 24'h0);
    chk("rst_busy_done", {busy, done}, 2'b00);
    chk("rst_errs", {e_early, e_miss, e_sof}, 3'b000);
    chk("rst_frames_done", fdone, 8'd0);
    rst = 0;
    gap(2);

    // Two clean frames
    clr_obs();
    pulse_start(2);
    send_frame(0, 0, -1, -1, -1, -1);
    gap(10);
    send_frame(0, 0, -1, -1, -1, -1);
    gap(20);
    chk("t1_beats", n_beats, 64);
    chk("t1_sof_count", sof_q.size(), 2);
    chk("t1_sof0", sof_at(0), 0);
    chk("t1_sof1", sof_at(1), 32);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_frames_done", fdone, 8'd2);
    chk("t1_errs", {e_early, e_miss, e_sof}, 3'b000);

    // Start while the source is at line 2
    clr_obs();
    pulse_start(2);
    send_frame(2, 0, -1, -1, -1, -1);
    gap(3);
    send_frame(0, 0, -1, -1, -1, -1);
    gap(10);
    send_frame(0, 0, -1, -1, -1, -1);
    gap(20);
    chk("t2_beats", n_beats, 64);
    chk("t2_sof0", sof_at(0), 0);
    chk("t2_sof1", sof_at(1), 32);
    chk("t2_frames_done", fdone, 8'd2);

    // SOF in the last drain cycle is dropped; the following frame is taken
    clr_obs();
    pulse_start(2);
    send_frame(0, 0, -1, -1, -1, -1);
    gap(DC - 1);
    send_frame(0, 0, -1, -1, -1, -1);
    gap(10);
    send_frame(0, 0, -1, -1, -1, -1);
    gap(20);
    chk("t7_beats", n_beats, 64);
    chk("t7_sof1", sof_at(1), 32);
    chk("t7_done_pulses", n_done, 1);
    chk("t7_frames_done", fdone, 8'd2);

    // Early EOL at x=5 of line 1
    clr_obs();
    pulse_start(1);
    send_frame(0, 1, 1, 5, -1, -1);
    chk("t3_err_early", e_early, 1'b1);
    chk("t3_busy", busy, 1'b0);
    chk("t3_beats", n_beats, 13);
    clr_obs();
    pulse_start(1);
    chk("t3_restart_clear", e_early, 1'b0);
    chk("t3_restart_busy", busy, 1'b1);
    send_frame(0, 0, -1, -1, -1, -1);
    gap(20);
    chk("t3_beats_after", n_beats, 32);
    chk("t3_done_after", n_done, 1);

    // Missing EOL at x=7, then a stray SOF mid-frame on a fresh run
    clr_obs();
    pulse_start(1);
    send_frame(0, 2, 0, 7, -1, -1);
    chk("t4_err_missing", e_miss, 1'b1);
    chk("t4_beats", n_beats, 7);
    pulse_start(1);
    send_frame(0, 3, 2, 3, -1, -1);
    chk("t4_err_sof", {e_early, e_miss, e_sof}, 3'b001);
    chk("t4_beats_total", n_beats, 26);
    pulse_abort();
    chk("t4_abort_clears", {e_early, e_miss, e_sof, busy}, 4'b0000);

    // Abort together with start at beat 20
    clr_obs();
    pulse_start(1);
    send_frame(0, 0, -1, -1, 20, -1);
    gap(20);
    chk("t5_beats", n_beats, 20);
    chk("t5_no_done", n_done, 0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_frames_done", fdone, 8'd0);

    // Asynchronous reset mid-frame, then a zero-frame start
    pulse_start(1);
    send_frame(0, 0, -1, -1, -1, 10);
    #2;
    rst = 1;
    #1;
    chk("t6_rst_tvalid", {m_tv, m_tu, m_tl}, 3'b000);
    chk("t6_rst_tdata", m_td, 24'h0);
    chk("t6_rst_flags", {busy, done, e_early, e_miss, e_sof}, 5'b00000);
    chk("t6_rst_frames_done", fdone, 8'd0);
    tick();
    rst = 0;
    gap(2);
    clr_obs();
    pulse_start(0);
    chk("t6_zero_start_busy", busy, 1'b0);
    send_frame(0, 0, -1, -1, -1, -1);
    gap(20);
    chk("t6_zero_start_beats", n_beats, 0);
    chk("t6_zero_start_done", n_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
